instr_fetch_unit: RTL

- Upstream fetch stage of the multicycle 16-bit RISC processor.
- Owns the PC register and the instruction register (IR).
- On a fetch request from the control FSM (IM_Read), it issues a handshaked read to instruction memory, latches the returned word into IR, and presents opcode = IR[15:12] to control.
- Applies PC updates driven by control (PC_Wr, PC_Wr_Cond, PC_Sel).

---
 rtl/instr_fetch_unit.sv | 115 +++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns PC and IR, runs the IDLE/WAIT/DONE handshake with instruction memory.
// Optional FETCH_COUNT_EN adds a counter of successfully fetched instructions.
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned TIMEOUT  = 15,
  parameter logic [15:0] NOP_WORD = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic        pc_wr,
  input  logic        pc_wr_cond,
  input  logic        alu_zero,
  input  logic        pc_sel,
  input  logic [15:0] pc_seq,
  input  logic [15:0] pc_target,
  output logic        im_req,
  output logic [15:0] im_addr,
  input  logic [15:0] im_rdata,
  input  logic        im_ack,
  output logic [15:0] pc,
  output logic [15:0] instr_reg,
  output logic [3:0]  opcode,
  output logic        ir_valid,
  output logic        fetch_done,
  output logic        fetch_busy,
  output logic        fetch_err,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  // Counter value on the last permitted WAIT cycle; WAIT lasts at most TIMEOUT cycles.
  localparam logic [3:0] TimeoutLast = 4'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [3:0] tcnt_q, tcnt_d;
  logic       wait_ack, wait_timeout, pc_load;

  assign wait_ack     = (state_q == StWait) && im_ack;
  assign wait_timeout = (state_q == StWait) && !im_ack && (tcnt_q == TimeoutLast);
  assign pc_load      = pc_wr | (pc_wr_cond & alu_zero);

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      StIdle: begin
        if (fetch_req) begin
          state_d = StWait;
          tcnt_d  = '0;
        end
      end
      StWait: begin
        if (wait_ack || wait_timeout) begin
          state_d = StDone;
        end else begin
          tcnt_d = tcnt_q + 4'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      tcnt_q    <= '0;
      im_addr   <= '0;
      instr_reg <= '0;
      ir_valid  <= 1'b0;
      fetch_err <= 1'b0;
      pc        <= RESET_PC;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      // Address is captured once per fetch so later PC writes cannot disturb it.
      if (state_q == StIdle && fetch_req) begin
        im_addr <= pc;
      end
      if (wait_ack) begin
        instr_reg <= im_rdata;
        ir_valid  <= 1'b1;
        fetch_err <= 1'b0;
      end else if (wait_timeout) begin
        instr_reg <= NOP_WORD;
        fetch_err <= 1'b1;
      end
      if (pc_load) begin
        pc <= pc_sel ? pc_target : pc_seq;
      end
    end
  end

`ifdef FETCH_COUNT_EN
  logic [15:0] fcnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= '0;
    end else if (wait_ack) begin
      fcnt_q <= fcnt_q + 16'd1;
    end
  end
  assign fetch_count = fcnt_q;
`else
  assign fetch_count = 16'h0000;
`endif

  assign im_req     = (state_q == StWait);
  assign fetch_busy = (state_q == StWait);
  assign fetch_done = (state_q == StDone);
  assign opcode     = instr_reg[15:12];

endmodule
